// File: rtl/spart_fifo.sv
// spart_fifo: buffered SPART UART with a programmable baud divisor, RX/TX FIFOs and sticky error status.
// Define SPART_PARITY_EN for 8E1 framing; the default build is 8N1.

module spart_fifo_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             nonempty,
  output logic             nonfull
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             do_push, do_pop;

  // A pop frees a slot on the same edge, so push+pop on a full FIFO both proceed.
  assign do_pop     = pop && nonempty;
  assign do_push    = push && (nonfull || do_pop);
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata      = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      nonempty <= 1'b0;
      nonfull  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      nonempty <= (count_next != '0);
      nonfull  <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module spart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RESET  = 16'd650
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);

  logic       wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic [15:0] div, baud_cnt;
  logic       tick;

  assign wr_en   = iocs && !iorw;
  assign rd_en   = iocs && iorw;
  assign wr_data = databus;
  assign databus = rd_en ? rd_data : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= DIV_RESET;
    end else if (wr_en && ioaddr == 2'd2) begin
      div[7:0] <= wr_data;
    end else if (wr_en && ioaddr == 2'd3) begin
      div[15:8] <= wr_data;
    end
  end

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) baud_cnt <= DIV_RESET;
    else     baud_cnt <= tick ? div : baud_cnt - 16'd1;
  end

  // ---------------- TX ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef SPART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t     tx_state;
  logic [7:0]    tx_head, tx_shift;
  logic [2:0]    tx_bcnt;
  logic [TW-1:0] tx_tcnt;
  logic          tx_nonempty, tx_pop;
`ifdef SPART_PARITY_EN
  logic          tx_par;
`endif

  spart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en && ioaddr == 2'd0),
    .pop      (tx_pop),
    .wdata    (wr_data),
    .rdata    (tx_head),
    .nonempty (tx_nonempty),
    .nonfull  (tbr)
  );

  assign tx_pop = tick && tx_nonempty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tcnt == T_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_shift <= '0;
      tx_bcnt  <= '0;
      tx_tcnt  <= '0;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tick) begin
      if (tx_pop) begin
        tx_state <= TX_START;
        txd      <= 1'b0;
        tx_shift <= tx_head;
        tx_tcnt  <= '0;
`ifdef SPART_PARITY_EN
        tx_par   <= ^tx_head;
`endif
      end else if (tx_state != TX_IDLE) begin
        if (tx_tcnt != T_LAST) begin
          tx_tcnt <= tx_tcnt + TW'(1);
        end else begin
          tx_tcnt <= '0;
          case (tx_state)
            TX_START: begin
              tx_state <= TX_DATA;
              txd      <= tx_shift[0];
              tx_bcnt  <= '0;
            end
            TX_DATA: begin
              if (tx_bcnt == 3'd7) begin
`ifdef SPART_PARITY_EN
                tx_state <= TX_PARITY;
                txd      <= tx_par;
`else
                tx_state <= TX_STOP;
                txd      <= 1'b1;
`endif
              end else begin
                tx_bcnt  <= tx_bcnt + 3'd1;
                tx_shift <= {1'b0, tx_shift[7:1]};
                txd      <= tx_shift[1];
              end
            end
`ifdef SPART_PARITY_EN
            TX_PARITY: begin
              tx_state <= TX_STOP;
              txd      <= 1'b1;
            end
`endif
            default: begin
              tx_state <= TX_IDLE;
              txd      <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef SPART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state;
  logic          rx_meta, rx_s;
  logic [7:0]    rx_shift, rx_head;
  logic [2:0]    rx_bcnt;
  logic [TW-1:0] rx_tcnt;
  logic          rx_sample, rx_push, rx_pop, rx_nonfull;
  logic          ovr_set, fe_set;
  logic          ovr, fe, pe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  spart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_push),
    .pop      (rx_pop),
    .wdata    (rx_shift),
    .rdata    (rx_head),
    .nonempty (rda),
    .nonfull  (rx_nonfull)
  );

  assign rx_pop    = rd_en && ioaddr == 2'd0;
  assign rx_sample = tick && (rx_tcnt == ((rx_state == RX_START) ? T_MID : T_LAST));
  assign rx_push   = (rx_state == RX_STOP) && rx_sample && rx_s;
  assign fe_set    = (rx_state == RX_STOP) && rx_sample && !rx_s;
  assign ovr_set   = rx_push && !rx_nonfull && !(rx_pop && rda);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_bcnt  <= '0;
      rx_tcnt  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_tcnt  <= '0;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else if (tick) begin
            rx_tcnt <= rx_tcnt + TW'(1);
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_tcnt  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bcnt == 3'd7) begin
`ifdef SPART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bcnt <= rx_bcnt + 3'd1;
            end
          end else if (tick) begin
            rx_tcnt <= rx_tcnt + TW'(1);
          end
        end
`ifdef SPART_PARITY_EN
        RX_PARITY: begin
          if (rx_sample) begin
            rx_tcnt  <= '0;
            rx_state <= RX_STOP;
          end else if (tick) begin
            rx_tcnt <= rx_tcnt + TW'(1);
          end
        end
`endif
        default: begin
          if (rx_sample) begin
            rx_tcnt  <= '0;
            rx_state <= RX_IDLE;
          end else if (tick) begin
            rx_tcnt <= rx_tcnt + TW'(1);
          end
        end
      endcase
    end
  end

  // Sticky status: a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
      fe  <= 1'b0;
    end else begin
      if (wr_en && ioaddr == 2'd1) begin
        if (wr_data[2]) ovr <= 1'b0;
        if (wr_data[3]) fe  <= 1'b0;
      end
      if (ovr_set) ovr <= 1'b1;
      if (fe_set)  fe  <= 1'b1;
    end
  end

`ifdef SPART_PARITY_EN
  logic pe_set;
  assign pe_set = (rx_state == RX_PARITY) && rx_sample && (rx_s != ^rx_shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe <= 1'b0;
    end else begin
      if (wr_en && ioaddr == 2'd1 && wr_data[4]) pe <= 1'b0;
      if (pe_set) pe <= 1'b1;
    end
  end
`else
  assign pe = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (ioaddr)
      2'd0:    rd_data = rda ? rx_head : 8'h00;
      2'd1:    rd_data = {3'b000, pe, fe, ovr, tbr, rda};
      2'd2:    rd_data = div[7:0];
      default: rd_data = div[15:8];
    endcase
  end
endmodule

// File: tb/tb_spart_fifo.sv
// Directed bench for spart_fifo in its default 8N1 build.
module tb_spart_fifo;
  localparam int DEPTH = 16;
  localparam int BIT   = 64;  // clocks per bit with divisor 3 and 16x oversampling

  logic       clk, rst, iocs, iorw, rxd_drv, loop_en, tb_drv;
  logic [1:0] ioaddr;
  logic [7:0] tb_wdata;
  logic       rda, tbr, txd, rxd;
  wire  [7:0] databus;
  int         total, bad;

  assign databus = tb_drv ? tb_wdata : 'z;
  assign rxd     = loop_en ? txd : rxd_drv;

  spart_fifo #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .DIV_RESET(16'd650)) dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_wdata = d; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic wait_rda(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = rda;
    end
  endtask

  task automatic wait_txd_low(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = !txd;
    end
  endtask

  // Stop-bit low is shortened so the line is high again before a false start is sampled.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd_drv = stop_lvl;
    repeat (stop_lvl ? BIT : 48) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if (tbr !== 1'b1) begin bad++; $display("FAIL reset_tbr got=%b exp=1", tbr); end
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL reset_rda got=%b exp=0", rda); end
    bus_read(2'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL reset_status got=%h exp=02", d); end
    bus_read(2'd2, d);
    total++; if (d !== 8'h8A) begin bad++; $display("FAIL reset_div_lo got=%h exp=8a", d); end
    bus_read(2'd3, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL reset_div_hi got=%h exp=02", d); end
  endtask

  task automatic test_loopback;
    logic [7:0] d;
    logic ok;
    int n;
    loop_en = 1'b1;
    bus_write(2'd3, 8'h00);
    bus_write(2'd2, 8'h03);
    bus_read(2'd2, d);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL loop_div_lo got=%h exp=03", d); end
    bus_write(2'd0, 8'h55);
    wait_txd_low(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_start_timeout got=0 exp=1"); end
    n = 0;
    while (!txd && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++; if (n != BIT) begin bad++; $display("FAIL loop_start_len got=%0d exp=%0d", n, BIT); end
    wait_rda(1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_rda_timeout got=0 exp=1"); end
    bus_read(2'd0, d);
    total++; if (d !== 8'h55) begin bad++; $display("FAIL loop_data got=%h exp=55", d); end
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL loop_rda_drop got=%b exp=0", rda); end
    bus_read(2'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL loop_status got=%h exp=02", d); end
  endtask

  task automatic test_tx_fill;
    logic [7:0] d, exp_b;
    logic ok;
    bus_write(2'd3, 8'h40);
    bus_write(2'd2, 8'h00);
    repeat (10) @(negedge clk);
    bus_write(2'd3, 8'h00);
    bus_write(2'd2, 8'h03);
    for (int i = 0; i <= DEPTH; i++) begin
      bus_write(2'd0, 8'(i));
      if (i == DEPTH - 2) begin
        total++; if (tbr !== 1'b1) begin bad++; $display("FAIL fill_tbr_15 got=%b exp=1", tbr); end
      end
      if (i >= DEPTH - 1) begin
        total++; if (tbr !== 1'b0) begin bad++; $display("FAIL fill_tbr_full%0d got=%b exp=0", i, tbr); end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'(i);
      wait_rda((i == 0) ? 20000 : 1500, ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_rx_timeout%0d got=0 exp=1", i); end
      bus_read(2'd0, d);
      total++; if (d !== exp_b) begin bad++; $display("FAIL fill_byte%0d got=%h exp=%h", i, d, exp_b); end
    end
    repeat (1500) @(negedge clk);
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL fill_extra_byte got=%b exp=0", rda); end
    total++; if (tbr !== 1'b1) begin bad++; $display("FAIL fill_tbr_end got=%b exp=1", tbr); end
    loop_en = 1'b0;
  endtask

  task automatic test_rx_overrun;
    logic [7:0] d, exp_b;
    rxd_drv = 1'b1;
    repeat (50) @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    repeat (100) @(negedge clk);
    bus_read(2'd1, d);
    total++; if (d !== 8'h07) begin bad++; $display("FAIL ovr_status_set got=%h exp=07", d); end
    bus_write(2'd1, 8'h04);
    bus_read(2'd1, d);
    total++; if (d !== 8'h03) begin bad++; $display("FAIL ovr_status_clr got=%h exp=03", d); end
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'hA0 + 8'(i);
      bus_read(2'd0, d);
      total++; if (d !== exp_b) begin bad++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, d, exp_b); end
    end
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b exp=0", rda); end
    bus_read(2'd0, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL ovr_empty_read got=%h exp=00", d); end
  endtask

  task automatic test_glitch_framing;
    logic [7:0] d;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL glitch_rda got=%b exp=0", rda); end
    bus_read(2'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL glitch_status got=%h exp=02", d); end
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    total++; if (rda !== 1'b0) begin bad++; $display("FAIL frame_rda got=%b exp=0", rda); end
    bus_read(2'd1, d);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL frame_status got=%h exp=0a", d); end
    bus_write(2'd1, 8'h08);
    bus_read(2'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL frame_clear got=%h exp=02", d); end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] d;
    logic ok;
    int lows;
    bus_write(2'd0, 8'hF0);
    bus_write(2'd0, 8'h0F);
    wait_txd_low(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_start_timeout got=0 exp=1"); end
    repeat (4 * BIT + 32) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL rst_bit3 got=%b exp=0", txd); end
    #2 rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_async_txd got=%b exp=1", txd); end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL rst_residual_bits got=%0d exp=0", lows); end
    total++; if (tbr !== 1'b1) begin bad++; $display("FAIL rst_tbr got=%b exp=1", tbr); end
    bus_read(2'd1, d);
    total++; if (d !== 8'h02) begin bad++; $display("FAIL rst_status got=%h exp=02", d); end
    bus_read(2'd2, d);
    total++; if (d !== 8'h8A) begin bad++; $display("FAIL rst_div_lo got=%h exp=8a", d); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'd0;
    tb_drv = 1'b0; tb_wdata = 8'h00; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_loopback;
    test_tx_fill;
    test_rx_overrun;
    test_glitch_framing;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
